// File: rtl/gpio_pio_pkg.sv
// Shared register map for the Avalon-MM GPIO PIO.
package gpio_pio_pkg;

  localparam int unsigned ADDR_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_DIR      = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_OUT_SET  = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_OUT_CLR  = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_RISE_EN  = 3'd6;
  localparam logic [ADDR_W-1:0] ADDR_FALL_EN  = 3'd7;

endpackage

// File: rtl/gpio_debounce.sv
// Per-bit debounce filter driven by a shared sample-tick prescaler.
// A bit only changes once the synchronised input has differed from the
// filtered level on DB_SAMPLES consecutive ticks. DEBOUNCE_DIV = 0 bypasses it.
module gpio_debounce
  import gpio_pio_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEBOUNCE_DIV = 0,
  parameter int unsigned DB_SAMPLES   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sync_i,
  output logic [WIDTH-1:0] filt_o
);

  if (DEBOUNCE_DIV == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset_n;
    assign filt_o         = sync_i;
  end else begin : g_filter
    localparam int unsigned PreW = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
    localparam int unsigned CntW = $clog2(DB_SAMPLES + 1);

    logic [PreW-1:0]  pre_q, pre_d;
    logic             tick;
    logic [CntW-1:0]  cnt_q [WIDTH];
    logic [CntW-1:0]  cnt_d [WIDTH];
    logic [WIDTH-1:0] filt_q, filt_d;

    // Tick on terminal count, then wrap.
    assign tick  = (pre_q == PreW'(DEBOUNCE_DIV - 1));
    assign pre_d = tick ? '0 : pre_q + PreW'(1);

    // Per-bit agreement counters; they hold between ticks.
    always_comb begin
      filt_d = filt_q;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_d[i] = cnt_q[i];
        if (tick) begin
          if (sync_i[i] == filt_q[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] + CntW'(1) == CntW'(DB_SAMPLES)) begin
            filt_d[i] = sync_i[i];
            cnt_d[i]  = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CntW'(1);
          end
        end
      end
    end

    // Prescaler, counters and filtered level; reset leaves no partial count.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        pre_q  <= '0;
        filt_q <= '0;
        for (int i = 0; i < WIDTH; i++) begin
          cnt_q[i] <= '0;
        end
      end else begin
        pre_q  <= pre_d;
        filt_q <= filt_d;
        for (int i = 0; i < WIDTH; i++) begin
          cnt_q[i] <= cnt_d[i];
        end
      end
    end

    assign filt_o = filt_q;
  end

endmodule

// File: rtl/gpio_pio_v2.sv
// Avalon-MM bidirectional PIO: register file, input synchroniser, edge
// capture with W1C, atomic set/clear of outputs, level IRQ and pad tristates.
module gpio_pio_v2
  import gpio_pio_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_DIV = 0,
  parameter int unsigned DB_SAMPLES   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              chipselect_i,
  input  logic              write_n_i,
  input  logic [31:0]       writedata_i,
  output logic [31:0]       readdata_o,
  output logic              irq_o,
  inout  wire  [WIDTH-1:0]  bidir_port_io
);

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rise, fall;
  logic [31:0]      readdata_q, readdata_d;

  assign wr = chipselect_i & ~write_n_i;
  assign wd = writedata_i[WIDTH-1:0];

  // Pads are driven only where the direction bit is set.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign bidir_port_io[i] = dir_q[i] ? data_out_q[i] : 1'bz;
  end

  // Input synchroniser; samples the pad even while driven so outputs read back.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= bidir_port_io;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

  gpio_debounce #(
    .WIDTH        (WIDTH),
    .DEBOUNCE_DIV (DEBOUNCE_DIV),
    .DB_SAMPLES   (DB_SAMPLES)
  ) u_debounce (
    .clk     (clk),
    .reset_n (reset_n),
    .sync_i  (sync_in),
    .filt_o  (filt)
  );

  assign rise = filt & ~prev_q & rise_en_q;
  assign fall = ~filt & prev_q & fall_en_q;

  // Register-file write decode; one register per cycle. Capture set wins over W1C.
  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    irq_mask_d = irq_mask_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    cap_clr    = '0;
    if (wr) begin
      case (address_i)
        ADDR_DATA:     data_out_d = wd;
        ADDR_DIR:      dir_d      = wd;
        ADDR_IRQ_MASK: irq_mask_d = wd;
        ADDR_EDGE_CAP: cap_clr    = wd;
        ADDR_OUT_SET:  data_out_d = data_out_q | wd;
        ADDR_OUT_CLR:  data_out_d = data_out_q & ~wd;
        ADDR_RISE_EN:  rise_en_d  = wd;
        ADDR_FALL_EN:  fall_en_d  = wd;
        default:       data_out_d = data_out_q;
      endcase
    end
    edge_cap_d = (edge_cap_q & ~cap_clr) | rise | fall;
  end

  // Read mux, registered every cycle regardless of chipselect.
  always_comb begin
    readdata_d = '0;
    case (address_i)
      ADDR_DATA:     readdata_d = 32'(filt);
      ADDR_DIR:      readdata_d = 32'(dir_q);
      ADDR_IRQ_MASK: readdata_d = 32'(irq_mask_q);
      ADDR_EDGE_CAP: readdata_d = 32'(edge_cap_q);
      ADDR_OUT_SET:  readdata_d = 32'(data_out_q);
      ADDR_OUT_CLR:  readdata_d = 32'(data_out_q);
      ADDR_RISE_EN:  readdata_d = 32'(rise_en_q);
      ADDR_FALL_EN:  readdata_d = 32'(fall_en_q);
      default:       readdata_d = '0;
    endcase
  end

  // Architectural state; rising-edge detection is enabled on all bits out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= '0;
      dir_q      <= '0;
      irq_mask_q <= '0;
      rise_en_q  <= '1;
      fall_en_q  <= '0;
      edge_cap_q <= '0;
      prev_q     <= '0;
      readdata_q <= '0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      irq_mask_q <= irq_mask_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      edge_cap_q <= edge_cap_d;
      prev_q     <= filt;
      readdata_q <= readdata_d;
    end
  end

  assign readdata_o = readdata_q;
  assign irq_o      = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_gpio_pio_v2.sv
// Bench for gpio_pio_v2: one unfiltered 32-bit instance (A) and one debounced
// 8-bit instance (B). Register reads go through an expected-value queue.
module tb_gpio_pio_v2;
  import gpio_pio_pkg::*;

  localparam int unsigned SyncStages = 2;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        cs_a, cs_b, write_n;
  logic [31:0] writedata;
  logic [31:0] rd_a, rd_b;
  logic        irq_a, irq_b;
  wire  [31:0] pad_a;
  wire  [7:0]  pad_b;
  logic [31:0] drv_a, en_a;
  logic [7:0]  drv_b, en_b;

  int          n_chk;
  int          n_err;
  logic [31:0] exp_q[$];

  typedef struct {
    bit          dut;
    bit          do_wr;
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  raddr;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  for (genvar i = 0; i < 32; i++) begin : g_pa
    assign pad_a[i] = en_a[i] ? drv_a[i] : 1'bz;
  end
  for (genvar i = 0; i < 8; i++) begin : g_pb
    assign pad_b[i] = en_b[i] ? drv_b[i] : 1'bz;
  end

  gpio_pio_v2 #(
    .WIDTH(32), .SYNC_STAGES(SyncStages), .DEBOUNCE_DIV(0), .DB_SAMPLES(4)
  ) u_dut_a (
    .clk(clk), .reset_n(reset_n), .address_i(address), .chipselect_i(cs_a),
    .write_n_i(write_n), .writedata_i(writedata), .readdata_o(rd_a), .irq_o(irq_a),
    .bidir_port_io(pad_a)
  );

  gpio_pio_v2 #(
    .WIDTH(8), .SYNC_STAGES(SyncStages), .DEBOUNCE_DIV(10), .DB_SAMPLES(4)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n), .address_i(address), .chipselect_i(cs_b),
    .write_n_i(write_n), .writedata_i(writedata), .readdata_o(rd_b), .irq_o(irq_b),
    .bidir_port_io(pad_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wr(input bit dut, input logic [2:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write_n   = 1'b0;
    if (dut) cs_b = 1'b1;
    else     cs_a = 1'b1;
    @(negedge clk);
    cs_a    = 1'b0;
    cs_b    = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic rd(input string name, input bit dut, input logic [2:0] a,
                    input logic [31:0] exp);
    address = a;
    exp_q.push_back(exp);
    @(negedge clk);
    check(name, dut ? rd_b : rd_a, exp_q.pop_front());
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic add_vec(input bit dut, input bit do_wr, input logic [2:0] waddr,
                         input logic [31:0] wdata, input logic [2:0] raddr,
                         input logic [31:0] exp);
    vec_t v;
    v.dut = dut; v.do_wr = do_wr; v.waddr = waddr; v.wdata = wdata;
    v.raddr = raddr; v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    bit found;
    int cyc;
    n_chk = 0; n_err = 0;
    address = '0; cs_a = 0; cs_b = 0; write_n = 1; writedata = '0;
    drv_a = '0; en_a = '1; drv_b = '0; en_b = '1;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    idle(3);
    check("rst_rd_a", rd_a, 32'h0);
    check("rst_irq_a", 32'(irq_a), 32'h0);
    check("rst_irq_b", 32'(irq_b), 32'h0);
    reset_n = 1'b1;
    idle(1);

    // Reset values of every register, then plain register write/readback.
    for (int a = 0; a < 8; a++) add_vec(0, 0, 3'd0, 32'h0, 3'(a), (a == 6) ? 32'hFFFF_FFFF : 32'h0);
    for (int a = 0; a < 8; a++) add_vec(1, 0, 3'd0, 32'h0, 3'(a), (a == 6) ? 32'h0000_00FF : 32'h0);
    add_vec(0, 1, ADDR_IRQ_MASK, 32'h1234_5678, ADDR_IRQ_MASK, 32'h1234_5678);
    add_vec(0, 1, ADDR_IRQ_MASK, 32'h0,         ADDR_IRQ_MASK, 32'h0);
    add_vec(0, 1, ADDR_FALL_EN,  32'hA5A5_A5A5, ADDR_FALL_EN,  32'hA5A5_A5A5);
    add_vec(0, 1, ADDR_FALL_EN,  32'h0,         ADDR_FALL_EN,  32'h0);
    add_vec(1, 1, ADDR_IRQ_MASK, 32'hFFFF_FFFF, ADDR_IRQ_MASK, 32'h0000_00FF);
    add_vec(1, 1, ADDR_IRQ_MASK, 32'h0,         ADDR_IRQ_MASK, 32'h0);
    add_vec(1, 1, ADDR_RISE_EN,  32'hFFFF_FF00, ADDR_RISE_EN,  32'h0);
    add_vec(1, 1, ADDR_RISE_EN,  32'h0000_00FF, ADDR_RISE_EN,  32'h0000_00FF);
    add_vec(0, 1, ADDR_DATA,     32'hDEAD_BEEF, ADDR_OUT_SET,  32'hDEAD_BEEF);
    add_vec(0, 1, ADDR_OUT_CLR,  32'hFFFF_0000, ADDR_OUT_CLR,  32'h0000_BEEF);
    add_vec(0, 1, ADDR_OUT_SET,  32'h0101_0000, ADDR_OUT_SET,  32'h0101_BEEF);
    add_vec(0, 1, ADDR_DATA,     32'h0,         ADDR_DATA,     32'h0);
    foreach (vecs[i]) begin
      if (vecs[i].do_wr) wr(vecs[i].dut, vecs[i].waddr, vecs[i].wdata);
      rd($sformatf("vec%0d", i), vecs[i].dut, vecs[i].raddr, vecs[i].exp);
    end

    // Drive pads and read them back through the input path.
    en_a = 32'hFFFF_FF00;
    wr(0, ADDR_DIR, 32'hFF);
    wr(0, ADDR_DATA, 32'h0F);
    wr(0, ADDR_OUT_SET, 32'h30);
    wr(0, ADDR_OUT_CLR, 32'h01);
    check("pads_drive", {24'h0, pad_a[7:0]}, 32'h3E);
    idle(2);
    rd("data_readback", 0, ADDR_DATA, 32'h3E);
    rd("out_clr_read", 0, ADDR_OUT_CLR, 32'h3E);

    // Falling-edge capture, IRQ, and W1C of other / own bits.
    wr(0, ADDR_DIR, 32'h0);
    drv_a = 32'h1; en_a = '1;
    idle(5);
    wr(0, ADDR_FALL_EN, 32'h1);
    wr(0, ADDR_RISE_EN, 32'h0);
    wr(0, ADDR_IRQ_MASK, 32'h1);
    wr(0, ADDR_EDGE_CAP, 32'hFFFF_FFFF);
    rd("cap_cleared", 0, ADDR_EDGE_CAP, 32'h0);
    check("irq_idle", 32'(irq_a), 32'h0);
    drv_a = 32'h0;
    idle(SyncStages + 1);
    check("irq_fall", 32'(irq_a), 32'h1);
    rd("cap_fall", 0, ADDR_EDGE_CAP, 32'h1);
    wr(0, ADDR_EDGE_CAP, 32'h2);
    check("irq_w1c_other", 32'(irq_a), 32'h1);
    rd("cap_w1c_other", 0, ADDR_EDGE_CAP, 32'h1);
    wr(0, ADDR_EDGE_CAP, 32'h1);
    check("irq_w1c_own", 32'(irq_a), 32'h0);
    rd("cap_w1c_own", 0, ADDR_EDGE_CAP, 32'h0);

    // Edge landing in the same cycle as a W1C of that bit must survive.
    drv_a = 32'h1; idle(5);
    drv_a = 32'h0; idle(5);
    check("irq_refall", 32'(irq_a), 32'h1);
    drv_a = 32'h1; idle(5);
    drv_a = 32'h0;
    idle(SyncStages);
    wr(0, ADDR_EDGE_CAP, 32'h1);
    rd("cap_set_wins", 0, ADDR_EDGE_CAP, 32'h1);
    wr(0, ADDR_IRQ_MASK, 32'h0);
    check("irq_mask_drop", 32'(irq_a), 32'h0);
    wr(0, ADDR_IRQ_MASK, 32'h1);
    check("irq_mask_back", 32'(irq_a), 32'h1);

    // Debounce: a short pulse is rejected, a held level is accepted once.
    drv_b[3] = 1'b1; idle(25);
    drv_b[3] = 1'b0; idle(60);
    rd("db_glitch_cap", 1, ADDR_EDGE_CAP, 32'h0);
    rd("db_glitch_data", 1, ADDR_DATA, 32'h0);
    drv_b[3] = 1'b1;
    address  = ADDR_DATA;
    found = 1'b0; cyc = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (!found && rd_b[3]) begin
        found = 1'b1;
        cyc   = c;
      end
    end
    check("db_seen", 32'(found), 32'h1);
    check("db_not_early", 32'(cyc >= 30), 32'h1);
    check("db_in_time", 32'(cyc <= 40 + SyncStages + 10), 32'h1);
    rd("db_single_cap", 1, ADDR_EDGE_CAP, 32'h08);
    wr(1, ADDR_EDGE_CAP, 32'h08);
    idle(30);
    rd("db_no_recap", 1, ADDR_EDGE_CAP, 32'h0);

    // Reset in the middle of a debounce count and of a read.
    drv_b[3] = 1'b0; idle(60);
    rd("db_fall_data", 1, ADDR_DATA, 32'h0);
    drv_b[3] = 1'b1; idle(25);
    address = ADDR_EDGE_CAP;
    @(negedge clk);
    check("pre_rst_rd", rd_a, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_rd_a", rd_a, 32'h0);
    check("rst_async_irq_a", 32'(irq_a), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    address = ADDR_DATA;
    idle(32);
    rd("rst_no_partial", 1, ADDR_DATA, 32'h0);
    idle(11);
    rd("rst_db_accept", 1, ADDR_DATA, 32'h08);
    rd("rst_cap_a", 0, ADDR_EDGE_CAP, 32'h0);
    rd("rst_mask_a", 0, ADDR_IRQ_MASK, 32'h0);
    rd("rst_rise_a", 0, ADDR_RISE_EN, 32'hFFFF_FFFF);
    rd("rst_fall_a", 0, ADDR_FALL_EN, 32'h0);
    check("rst_irq_after", 32'(irq_a), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
